// File: rtl/pma_region_loader.sv
// Boots the PMA region table from a memory image, then reads every field back and verifies it.
// Define PMA_LOADER_LOCK_EN to add a `locked` output that freezes the loader after a clean load.
module pma_region_loader #(
  parameter int NREG = 8,
  parameter int NFLD = 5,
  parameter int VWID = 64,
  parameter int CMPW = 32,
  parameter int ATW  = 20,
  parameter int AWID = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AWID-1:0] base,
  output logic            mem_req,
  output logic [AWID-1:0] mem_adr,
  input  logic            mem_ack,
  input  logic            mem_err,
  input  logic [VWID-1:0] mem_dat,
  output logic            tbl_wr,
  output logic [5:0]      tbl_rwa,
  output logic [VWID-1:0] tbl_dat_o,
  input  logic [VWID-1:0] tbl_dat_i,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [5:0]      err_rwa
`ifdef PMA_LOADER_LOCK_EN
  ,
  output logic            locked
`endif
);

  localparam logic [2:0] FLD_LAST = 3'(NFLD-1);
  localparam logic [2:0] REG_LAST = 3'(NREG-1);
  localparam logic [2:0] AT_FLD   = 3'd4;
  localparam logic [1:0] EC_BUS   = 2'd1;
  localparam logic [1:0] EC_VFY   = 2'd2;
  localparam int         BPW      = VWID/8;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_VREAD, S_VCMP, S_FIN} state_e;

  typedef struct packed {
    logic       flag;
    logic [1:0] code;
    logic [5:0] rwa;
  } err_rec_t;

  state_e          state_q, state_d;
  logic [2:0]      reg_q, reg_d, fld_q, fld_d;
  logic            vfy_q, vfy_d;
  logic [AWID-1:0] base_q, base_d;
  logic [VWID-1:0] dat_q, dat_d;
  err_rec_t        erec_q, erec_d;

  logic            lock_w;
  logic            last_fld, last_all, cmp_ok;
  logic [2:0]      reg_nx, fld_nx;
  logic [AWID-1:0] word_idx;
  logic            unused_hi;

  assign word_idx  = AWID'(reg_q) * AWID'(NFLD) + AWID'(fld_q);
  assign mem_adr   = base_q + word_idx * AWID'(BPW);
  assign tbl_rwa   = {reg_q, fld_q};
  assign tbl_dat_o = dat_q;
  assign err       = erec_q.flag;
  assign err_code  = erec_q.code;
  assign err_rwa   = erec_q.rwa;
  assign unused_hi = ^tbl_dat_i[VWID-1:CMPW];

  always_comb begin
    last_fld = (fld_q == FLD_LAST);
    last_all = last_fld && (reg_q == REG_LAST);
    fld_nx   = last_fld ? 3'd0 : fld_q + 3'd1;
    reg_nx   = last_fld ? reg_q + 3'd1 : reg_q;
  end

  // Only the architecturally meaningful low bits of each field are held by the table.
  assign cmp_ok = (fld_q == AT_FLD) ? (tbl_dat_i[ATW-1:0]  == dat_q[ATW-1:0])
                                    : (tbl_dat_i[CMPW-1:0] == dat_q[CMPW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      reg_q   <= '0;
      fld_q   <= '0;
      vfy_q   <= 1'b0;
      base_q  <= '0;
      dat_q   <= '0;
      erec_q  <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      fld_q   <= fld_d;
      vfy_q   <= vfy_d;
      base_q  <= base_d;
      dat_q   <= dat_d;
      erec_q  <= erec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    fld_d   = fld_q;
    vfy_d   = vfy_q;
    base_d  = base_q;
    dat_d   = dat_q;
    erec_d  = erec_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !lock_w) begin
          base_d  = base;
          erec_d  = '0;
          reg_d   = '0;
          fld_d   = '0;
          vfy_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          if (mem_err) begin
            erec_d  = '{flag: 1'b1, code: EC_BUS, rwa: tbl_rwa};
            state_d = S_FIN;
          end else begin
            dat_d   = mem_dat;
            state_d = vfy_q ? S_VREAD : S_WRITE;
          end
        end
      end
      S_WRITE: begin
        state_d = S_FETCH;
        if (last_all) begin
          reg_d = '0;
          fld_d = '0;
          vfy_d = 1'b1;
        end else begin
          reg_d = reg_nx;
          fld_d = fld_nx;
        end
      end
      S_VREAD: state_d = S_VCMP;
      S_VCMP: begin
        if (!cmp_ok) begin
          erec_d  = '{flag: 1'b1, code: EC_VFY, rwa: tbl_rwa};
          state_d = S_FIN;
        end else if (last_all) begin
          reg_d   = '0;
          fld_d   = '0;
          state_d = S_FIN;
        end else begin
          reg_d   = reg_nx;
          fld_d   = fld_nx;
          state_d = S_FETCH;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == S_FETCH);
    tbl_wr  = (state_q == S_WRITE);
    done    = (state_q == S_FIN);
    busy    = (state_q != S_IDLE);
  end

`ifdef PMA_LOADER_LOCK_EN
  logic lock_q, lock_d;

  // Sticky until reset: a clean load freezes the table contents.
  always_comb lock_d = lock_q | ((state_q == S_FIN) && !erec_q.flag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end

  assign lock_w = lock_q;
  assign locked = lock_q;
`else
  assign lock_w = 1'b0;
`endif

endmodule

// File: tb/tb_pma_region_loader.sv
// Self-checking bench for pma_region_loader: random-latency memory, mirror table model,
// and a field-level reference model of the expected load/verify outcome.
module tb_pma_region_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] base = '0;
  logic        mem_req, mem_ack = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_adr;
  logic [63:0] mem_dat = '0;
  logic        tbl_wr;
  logic [5:0]  tbl_rwa;
  logic [63:0] tbl_dat_o, tbl_dat_i = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [5:0]  err_rwa;
`ifdef PMA_LOADER_LOCK_EN
  logic        locked;
`endif

  always #5 clk = ~clk;

  pma_region_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack), .mem_err(mem_err), .mem_dat(mem_dat),
    .tbl_wr(tbl_wr), .tbl_rwa(tbl_rwa), .tbl_dat_o(tbl_dat_o), .tbl_dat_i(tbl_dat_i),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_rwa(err_rwa)
`ifdef PMA_LOADER_LOCK_EN
    , .locked(locked)
`endif
  );

  logic [63:0] mem [logic [31:0]];
  logic [63:0] tbl  [64];
  logic [63:0] corr [64];
  logic [63:0] rd_nxt = '0;
  bit          inj_en = 1'b0;
  logic [31:0] inj_adr = '0;
  int          lat_max = 0, lat = 0;
  bit          pending = 1'b0;
  logic [5:0]  wr_rwa_q [$];
  logic [63:0] wr_dat_q [$];
  logic [31:0] adr_q [$];
  int          done_cnt = 0;
  int          chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;

  function automatic logic [63:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic logic [5:0] rwa_of(input int k);
    return 6'(((k / 5) << 3) | (k % 5));
  endfunction

  // Table mirror (registered read) and memory responder with random ack latency.
  always @(negedge clk) begin
    if (tbl_wr) begin
      tbl[tbl_rwa] = tbl_dat_o ^ corr[tbl_rwa];
      wr_rwa_q.push_back(tbl_rwa);
      wr_dat_q.push_back(tbl_dat_o);
    end
    tbl_dat_i = rd_nxt;
    rd_nxt    = tbl[tbl_rwa];
    if (done) done_cnt++;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    if (mem_req) begin
      if (!pending) begin
        pending = 1'b1;
        lat     = $urandom_range(lat_max, 0);
      end
      if (lat == 0) begin
        mem_ack = 1'b1;
        mem_dat = rd_mem(mem_adr);
        mem_err = inj_en && (mem_adr == inj_adr);
        pending = 1'b0;
        adr_q.push_back(mem_adr);
      end else begin
        lat--;
      end
    end else begin
      pending = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Outcome of one load from the image, corruption plan and bus-error plan.
  task automatic model(input logic [31:0] b, output int ewr, output int eack,
                       output logic eerr, output logic [1:0] ecode, output logic [5:0] erwa);
    logic [63:0] m;
    ewr = 0; eack = 0; eerr = 1'b0; ecode = 2'd0; erwa = 6'd0;
    for (int k = 0; k < 40; k++) begin
      eack++;
      if (inj_en && (b + 32'(8*k)) == inj_adr) begin
        eerr = 1'b1; ecode = 2'd1; erwa = rwa_of(k);
        return;
      end
      ewr++;
    end
    for (int k = 0; k < 40; k++) begin
      eack++;
      if (inj_en && (b + 32'(8*k)) == inj_adr) begin
        eerr = 1'b1; ecode = 2'd1; erwa = rwa_of(k);
        return;
      end
      m = (k % 5 == 4) ? 64'h000F_FFFF : 64'hFFFF_FFFF;
      if ((corr[rwa_of(k)] & m) != 64'h0) begin
        eerr = 1'b1; ecode = 2'd2; erwa = rwa_of(k);
        return;
      end
    end
  endtask

  task automatic load_image(input logic [31:0] b);
    for (int k = 0; k < 40; k++) mem[b + 32'(8*k)] = {$urandom, $urandom};
    if (b == 32'h1000) begin
      mem[b + 32'(8*35)] = 64'hFFFD_0000;
      mem[b + 32'(8*36)] = 64'hFFFF_FFFF;
      mem[b + 32'(8*37)] = 64'h0;
      mem[b + 32'(8*38)] = 64'h0;
      mem[b + 32'(8*39)] = 64'h0000_000D;
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 64; i++) corr[i] = 64'h0;
    inj_en = 1'b0;
  endtask

  task automatic clear_mon();
    @(posedge clk); #1;
    wr_rwa_q.delete(); wr_dat_q.delete(); adr_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_load(input logic [31:0] b, output int cyc);
    clear_mon();
    @(negedge clk); base = b; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_load(input string t, input logic [31:0] b);
    int ewr, eack, bad;
    logic eerr;
    logic [1:0] ecode;
    logic [5:0] erwa;
    model(b, ewr, eack, eerr, ecode, erwa);
    chk({t, ".wr_cnt"},   wr_rwa_q.size(), ewr);
    chk({t, ".ack_cnt"},  adr_q.size(), eack);
    chk({t, ".err"},      err, eerr);
    chk({t, ".err_code"}, err_code, ecode);
    chk({t, ".err_rwa"},  err_rwa, erwa);
    chk({t, ".done_cnt"}, done_cnt, 1);
    bad = 0;
    foreach (wr_rwa_q[i])
      if (wr_rwa_q[i] !== rwa_of(i) || wr_dat_q[i] !== rd_mem(b + 32'(8*i))) bad++;
    chk({t, ".wr_seq"}, bad, 0);
    bad = 0;
    foreach (adr_q[i]) if (adr_q[i] !== b + 32'(8*(i % 40))) bad++;
    chk({t, ".adr_seq"}, bad, 0);
  endtask

  // Lock build: a clean load freezes the loader, so reset between scenarios.
  task automatic unlock();
`ifdef PMA_LOADER_LOCK_EN
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
`endif
  endtask

  initial begin
    int cyc, bad;
    for (int i = 0; i < 64; i++) tbl[i] = 64'h0;
    clear_plan();
    repeat (3) @(negedge clk);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_adr", mem_adr, 0);
    chk("rst.tbl_wr", tbl_wr, 0);
    chk("rst.tbl_rwa", tbl_rwa, 0);
    chk("rst.tbl_dat_o", tbl_dat_o, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.err_code", err_code, 0);
    chk("rst.err_rwa", err_rwa, 0);
`ifdef PMA_LOADER_LOCK_EN
    chk("rst.locked", locked, 0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Zero-wait load of the reference image: exact latency and table contents.
    load_image(32'h1000);
    lat_max = 0;
    run_load(32'h1000, cyc);
    chk("t1.latency", cyc, 201);
    check_load("t1", 32'h1000);
    chk("t1.r7f0", tbl[6'h38], 64'hFFFD_0000);
    chk("t1.r7f1", tbl[6'h39], 64'hFFFF_FFFF);
    chk("t1.r7f4", tbl[6'h3C], 64'h0000_000D);

`ifdef PMA_LOADER_LOCK_EN
    chk("lk.locked", locked, 1);
    clear_mon();
    @(negedge clk); base = 32'h1000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    chk("lk.acks", adr_q.size(), 0);
    chk("lk.done", done_cnt, 0);
    chk("lk.busy", busy, 0);
    chk("lk.err_code", err_code, 0);
    rst_n = 1'b0; #1;
    chk("lk.locked_rst", locked, 0);
    @(negedge clk); rst_n = 1'b1;
`endif

    // Random ack latency, same image.
    lat_max = 3;
    run_load(32'h1000, cyc);
    check_load("t2", 32'h1000);

    // Address wrap past 2^32.
    unlock();
    load_image(32'hFFFF_FFE0);
    run_load(32'hFFFF_FFE0, cyc);
    check_load("t3", 32'hFFFF_FFE0);

    // Region 2 at-field readback bit 3 flipped.
    unlock();
    clear_plan();
    corr[6'h14] = 64'h8;
    run_load(32'h1000, cyc);
    check_load("t4", 32'h1000);
    chk("t4.code2", err_code, 2);
    chk("t4.rwa14", err_rwa, 6'h14);

    // Bus error on k = 11 during the write pass.
    unlock();
    clear_plan();
    inj_en  = 1'b1;
    inj_adr = 32'h1000 + 32'(8*11);
    run_load(32'h1000, cyc);
    check_load("t5", 32'h1000);
    chk("t5.rwa11", err_rwa, 6'h11);
    repeat (10) @(negedge clk);
    chk("t5.no_wr_after", wr_rwa_q.size(), 11);

    // Upper don't-care bits corrupted: must still pass, and the old error is cleared.
    unlock();
    clear_plan();
    corr[6'h04] = 64'hFFFF_FFFF_FFF0_0000;
    corr[6'h22] = 64'hFFFF_FFFF_0000_0000;
    corr[6'h3C] = 64'hFFF0_0000_0000_0000;
    run_load(32'h1000, cyc);
    check_load("t6", 32'h1000);

    // Start while busy is ignored; reset mid-fetch abandons at once; fresh load from new base.
    unlock();
    clear_plan();
    load_image(32'h3000);
    load_image(32'h2000);
    clear_mon();
    @(negedge clk); base = 32'h3000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    base = 32'h2000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t7.in_fetch", mem_req, 1);
    chk("t7.busy_mid", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7.rst_mem_req", mem_req, 0);
    chk("t7.rst_tbl_wr", tbl_wr, 0);
    chk("t7.rst_busy", busy, 0);
    chk("t7.acks_seen", adr_q.size() > 0, 1);
    bad = 0;
    foreach (adr_q[i]) if (adr_q[i] !== 32'h3000 + 32'(8*i)) bad++;
    chk("t7.old_base_kept", bad, 0);
    @(negedge clk); rst_n = 1'b1;
    run_load(32'h2000, cyc);
    check_load("t7b", 32'h2000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
